blake_g_sched: RTL and testbench

Round scheduler for the BLAKE-256/Blakecoin compression function. It time-multiplexes one external, fully pipelined G unit across the eight G evaluations of every round. It holds the 16-word working state v and the 16-word message block. It generates the sigma-permuted, constant-XORed message words and issues column and diagonal G operations in the correct dependency order. It sits between the block loader and the finalization XOR (h' = h ^ s ^ v_lo ^ v_hi), which is outside this block.

---
 rtl/blake_g_sched.sv | 170 +++++++++++++++++
 tb/tb_blake_g_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/blake_g_sched.sv
// BLAKE-256 round scheduler: holds v and m, issues the eight G evaluations of each
// round to one external pipelined G unit and writes the results back by tag.
module blake_g_sched #(
  parameter int ROUNDS = 8,
  parameter int G_LAT  = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] v_in,
  input  logic [511:0] msg_in,
  output logic         busy,
  output logic         done,
  output logic [511:0] v_out,
  output logic [31:0]  g_a,
  output logic [31:0]  g_b,
  output logic [31:0]  g_c,
  output logic [31:0]  g_d,
  output logic [31:0]  g_msg_i,
  output logic [31:0]  g_msg_ip,
  input  logic [31:0]  g_a_out,
  input  logic [31:0]  g_b_out,
  input  logic [31:0]  g_c_out,
  input  logic [31:0]  g_d_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [15:0][31:0] BLAKE_C = {
    32'hB5470917, 32'h3F84D5B5, 32'hC97C50DD, 32'hC0AC29B7,
    32'h34E90C6C, 32'hBE5466CF, 32'h38D01377, 32'h452821E6,
    32'hEC4E6C89, 32'h082EFA98, 32'h299F31D0, 32'hA4093822,
    32'h03707344, 32'h13198A2E, 32'h85A308D3, 32'h243F6A88
  };

  // Row r lists sigma_r(0..15) most-significant nibble first.
  localparam logic [9:0][63:0] SIGMA = {
    64'hA2847615FB9E3CD0, 64'h6FE9B308C2D714A5, 64'hDB7EC13950F4862A,
    64'hC51FED4A0763928B, 64'h2C6A0B834D75FE19, 64'h905724AFE1BC683D,
    64'h7931DCBE265A40F8, 64'hB8C052FDAE367194, 64'hEA489FD61C02B753,
    64'h0123456789ABCDEF
  };

  state_t            state_q, state_d;
  logic [1:0]        slot_q, slot_d;
  logic              diag_q, diag_d;
  logic [3:0]        round_q, round_d;
  logic [3:0]        sig_q, sig_d;
  logic [3:0]        tag_q [G_LAT];
  logic [3:0]        tag_in, tag_out;
  logic [15:0][31:0] v_q, m_q;
  logic [2:0]        g_idx;
  logic [63:0]       sig_row;
  logic [3:0]        e_even, e_odd, s_even, s_odd;
  logic              load_en, wb_en, wb_last;

  // Lane 0..3 selects a,b,c,d. Diagonals rotate the column by the lane number.
  function automatic logic [3:0] quad_idx(input logic [2:0] g, input logic [1:0] lane);
    logic [1:0] col;
    col = g[2] ? g[1:0] + lane : g[1:0];
    return {lane, col};
  endfunction

  assign g_idx   = {diag_q, slot_q};
  assign tag_in  = {state_q == S_ISSUE, g_idx};
  assign tag_out = tag_q[G_LAT-1];
  assign wb_en   = tag_out[3] && !reset;
  assign wb_last = tag_out[3] && (tag_out[1:0] == 2'd3);
  assign load_en = (state_q == S_IDLE) && start && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      slot_q  <= 2'd0;
      diag_q  <= 1'b0;
      round_q <= 4'd0;
      sig_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      diag_q  <= diag_d;
      round_q <= round_d;
      sig_q   <= sig_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    diag_d  = diag_q;
    round_d = round_q;
    sig_d   = sig_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ISSUE;
        slot_d  = 2'd0;
        diag_d  = 1'b0;
        round_d = 4'd0;
        sig_d   = 4'd0;
      end
      S_ISSUE: begin
        slot_d = slot_q + 2'd1;
        if (slot_q == 2'd3) state_d = S_DRAIN;
      end
      S_DRAIN: if (wb_last) begin
        if (!diag_q) begin
          diag_d  = 1'b1;
          state_d = S_ISSUE;
        end else if (round_q == 4'(ROUNDS - 1)) begin
          state_d = S_DONE;
        end else begin
          diag_d  = 1'b0;
          round_d = round_q + 4'd1;
          sig_d   = (sig_q == 4'd9) ? 4'd0 : sig_q + 4'd1;
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_ISSUE, S_DRAIN: busy = 1'b1;
      S_DONE:           done = 1'b1;
      default:          ;
    endcase
  end

  // The tag of an issue reaches the last stage in the cycle its G result is readable.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < G_LAT; j++) tag_q[j] <= 4'd0;
    end else begin
      tag_q[0] <= tag_in;
      for (int j = 1; j < G_LAT; j++) tag_q[j] <= tag_q[j-1];
    end
  end

  // NOTE: v and m carry no reset; their contents are meaningless until a start loads them.
  always_ff @(posedge clk) begin
    if (load_en) begin
      v_q <= v_in;
      m_q <= msg_in;
    end else if (wb_en) begin
      v_q[quad_idx(tag_out[2:0], 2'd0)] <= g_a_out;
      v_q[quad_idx(tag_out[2:0], 2'd1)] <= g_b_out;
      v_q[quad_idx(tag_out[2:0], 2'd2)] <= g_c_out;
      v_q[quad_idx(tag_out[2:0], 2'd3)] <= g_d_out;
    end
  end

  assign sig_row  = SIGMA[sig_q];
  assign e_even   = {g_idx, 1'b0};
  assign e_odd    = {g_idx, 1'b1};
  assign s_even   = sig_row[{~e_even, 2'b00} +: 4];
  assign s_odd    = sig_row[{~e_odd, 2'b00} +: 4];
  assign g_a      = v_q[quad_idx(g_idx, 2'd0)];
  assign g_b      = v_q[quad_idx(g_idx, 2'd1)];
  assign g_c      = v_q[quad_idx(g_idx, 2'd2)];
  assign g_d      = v_q[quad_idx(g_idx, 2'd3)];
  assign g_msg_i  = m_q[s_even] ^ BLAKE_C[s_odd];
  assign g_msg_ip = m_q[s_odd] ^ BLAKE_C[s_even];
  assign v_out    = v_q;

endmodule

// File: tb/tb_blake_g_sched.sv
// Bench for blake_g_sched: four parameterisations, each driving a behavioural G unit,
// checked against a software BLAKE-256 round model and the one-byte known answer.
module tb_blake_g_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start_a  [4];
  logic [511:0] v_in_a   [4];
  logic [511:0] msg_in_a [4];
  wire          busy_w   [4];
  wire          done_w   [4];
  wire  [511:0] v_out_w  [4];

  int n_checks = 0;
  int n_errors = 0;

  localparam int unsigned C_TAB [16] = '{
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
    32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
    32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917};
  localparam int unsigned IV [8] = '{
    32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
    32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
  localparam int SIG [10][16] = '{
    '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
    '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
    '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
    '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
    '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
    '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
    '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
    '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
    '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}};
  localparam int QD [8][4] = '{
    '{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
    '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};

  function automatic int cfg_rounds(input int i);
    return (i == 1) ? 14 : 8;
  endfunction

  function automatic int cfg_lat(input int i);
    return (i == 2) ? 1 : ((i == 3) ? 15 : 6);
  endfunction

  function automatic int unsigned rotr(input int unsigned x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Returns {d, c, b, a}.
  function automatic logic [127:0] g_fn(input int unsigned a, b, c, d, mi, mip);
    a = a + b + mi;  d = rotr(d ^ a, 16); c = c + d; b = rotr(b ^ c, 12);
    a = a + b + mip; d = rotr(d ^ a, 8);  c = c + d; b = rotr(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  function automatic logic [511:0] model(input logic [511:0] vin, min, input int rounds);
    int unsigned v [16];
    int unsigned m [16];
    logic [127:0] res;
    logic [511:0] out;
    for (int w = 0; w < 16; w++) begin
      v[w] = vin[32*w +: 32];
      m[w] = min[32*w +: 32];
    end
    for (int r = 0; r < rounds; r++) begin
      for (int g = 0; g < 8; g++) begin
        int s;
        s = r % 10;
        res = g_fn(v[QD[g][0]], v[QD[g][1]], v[QD[g][2]], v[QD[g][3]],
                   m[SIG[s][2*g]] ^ C_TAB[SIG[s][2*g+1]],
                   m[SIG[s][2*g+1]] ^ C_TAB[SIG[s][2*g]]);
        v[QD[g][0]] = res[31:0];
        v[QD[g][1]] = res[63:32];
        v[QD[g][2]] = res[95:64];
        v[QD[g][3]] = res[127:96];
      end
    end
    for (int w = 0; w < 16; w++) out[32*w +: 32] = v[w];
    return out;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : cfg
    localparam int R = cfg_rounds(gi);
    localparam int L = cfg_lat(gi);
    logic [31:0]  ga, gb, gc, gd, gmi, gmip;
    logic [127:0] pipe [L];
    logic [127:0] gout;
    assign gout = pipe[L-1];

    blake_g_sched #(.ROUNDS(R), .G_LAT(L)) u_dut (
      .clk(clk), .reset(reset), .start(start_a[gi]),
      .v_in(v_in_a[gi]), .msg_in(msg_in_a[gi]),
      .busy(busy_w[gi]), .done(done_w[gi]), .v_out(v_out_w[gi]),
      .g_a(ga), .g_b(gb), .g_c(gc), .g_d(gd), .g_msg_i(gmi), .g_msg_ip(gmip),
      .g_a_out(gout[31:0]), .g_b_out(gout[63:32]),
      .g_c_out(gout[95:64]), .g_d_out(gout[127:96]));

    // G unit with no valid: it evaluates every cycle and presents results L cycles later.
    always @(posedge clk) begin
      pipe[0] <= g_fn(ga, gb, gc, gd, gmi, gmip);
      for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] x;
    for (int w = 0; w < 16; w++) x[32*w +: 32] = $urandom;
    return x;
  endfunction

  // One compression (two back-to-back when hold is set), counted from the start cycle 0.
  task automatic run_cfg(input int i, input logic [511:0] v, input logic [511:0] m,
                         input bit hold, input bit pulses, input string tag,
                         output logic [511:0] res);
    int p, last, first_done, last_done, n_done, busy_bad;
    logic busy_exp;
    logic [511:0] exp_v;
    exp_v = model(v, m, cfg_rounds(i));
    p = 2 * cfg_rounds(i) * (cfg_lat(i) + 4) + 1;
    last = hold ? 2 * p + 1 : p;
    first_done = -1; last_done = -1; n_done = 0; busy_bad = 0;
    res = 'x;
    @(negedge clk);
    check({tag, " idle busy"}, busy_w[i], 0);
    check({tag, " idle done"}, done_w[i], 0);
    v_in_a[i] = v; msg_in_a[i] = m; start_a[i] = 1'b1;
    for (int cyc = 1; cyc <= last + 1; cyc++) begin
      @(negedge clk);
      busy_exp = (cyc < p) || (hold && cyc > p + 1 && cyc < 2 * p + 1);
      if (busy_w[i] !== busy_exp) busy_bad++;
      if (done_w[i] === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = cyc;
        last_done = cyc;
        check({tag, " v_out"}, v_out_w[i], exp_v);
        res = v_out_w[i];
      end
      start_a[i] = (cyc <= last) && (hold || (pulses && (cyc == 5 || cyc == 50 || cyc == 160)));
    end
    start_a[i] = 1'b0;
    check({tag, " first done cycle"}, first_done, p);
    check({tag, " last done cycle"}, last_done, last);
    check({tag, " done pulses"}, n_done, hold ? 2 : 1);
    check({tag, " busy profile errors"}, busy_bad, 0);
  endtask

  // Start a run, reset it at rst_cyc, and return so the next run starts at restart_cyc.
  task automatic abort_run(input int i, input logic [511:0] v, input logic [511:0] m,
                           input int rst_cyc, input int restart_cyc, input string tag);
    @(negedge clk);
    v_in_a[i] = v; msg_in_a[i] = m; start_a[i] = 1'b1;
    for (int cyc = 1; cyc < restart_cyc; cyc++) begin
      @(negedge clk);
      start_a[i] = 1'b0;
      if (cyc == rst_cyc) begin
        reset = 1'b1;
      end else if (cyc == rst_cyc + 1) begin
        check({tag, " busy after reset"}, busy_w[i], 0);
        check({tag, " done after reset"}, done_w[i], 0);
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    logic [511:0] res, v_kat, m_kat;
    logic [255:0] hash;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_a[i] = 1'b0; v_in_a[i] = '0; msg_in_a[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset busy cfg%0d", i), busy_w[i], 0);
      check($sformatf("reset done cfg%0d", i), done_w[i], 0);
    end
    reset = 1'b0;

    run_cfg(0, '0, '0, 1'b0, 1'b0, "zero r8 l6", res);
    run_cfg(0, '0, '0, 1'b0, 1'b1, "ignored starts", res);

    // One-byte 0x00 message, counter t=8, 14 rounds.
    v_kat = '0; m_kat = '0;
    for (int w = 0; w < 8; w++) v_kat[32*w +: 32] = IV[w];
    for (int w = 0; w < 8; w++) v_kat[32*(w+8) +: 32] = C_TAB[w];
    v_kat[32*12 +: 32] = C_TAB[4] ^ 32'd8;
    v_kat[32*13 +: 32] = C_TAB[5] ^ 32'd8;
    m_kat[31:0] = 32'h00800000;
    m_kat[32*13 +: 32] = 32'h00000001;
    m_kat[32*15 +: 32] = 32'h00000008;
    run_cfg(1, v_kat, m_kat, 1'b0, 1'b0, "kat r14", res);
    for (int w = 0; w < 8; w++)
      hash[32*(7-w) +: 32] = IV[w] ^ res[32*w +: 32] ^ res[32*(w+8) +: 32];
    check("kat hash", {256'd0, hash},
          {256'd0, 256'h0ce8d4ef4dd7cd8d62dfded9d4edb0a774ae6a41929a74da23109e8f11139c87});

    run_cfg(1, rand512(), rand512(), 1'b0, 1'b0, "rand r14", res);
    run_cfg(2, rand512(), rand512(), 1'b0, 1'b0, "rand lat1", res);
    run_cfg(3, rand512(), rand512(), 1'b0, 1'b0, "rand lat15", res);
    run_cfg(0, rand512(), rand512(), 1'b0, 1'b0, "rand r8 l6", res);

    abort_run(0, rand512(), rand512(), 40, 45, "reset drain");
    run_cfg(0, rand512(), rand512(), 1'b0, 1'b0, "after reset drain", res);
    abort_run(0, rand512(), rand512(), 33, 35, "reset issue");
    run_cfg(0, rand512(), rand512(), 1'b0, 1'b0, "after reset issue", res);

    run_cfg(0, rand512(), rand512(), 1'b1, 1'b0, "start held", res);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
